// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: registered fetch port, NOOP fill after reset,
// and run-time reprogramming from a little-endian byte stream.
module instr_mem_loadable #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 64,
    parameter int                ADDR_W = 6,
    parameter logic [DATA_W-1:0] NOOP   = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              load_start,
    input  logic [7:0]        load_byte,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_end,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_LOAD
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   clr_ptr, wr_ptr, mem_waddr;
    logic [BC_W-1:0]     byte_cnt;
    logic [DATA_W-1:0]   asm_reg, asm_word, mem_wdata;
    logic                mem_we, accept, word_done, fetch_in_range;

    logic [DATA_W-1:0]   mem [DEPTH];

    // When the address space is exactly DEPTH words, every address is valid.
    if ((1 << ADDR_W) > DEPTH) begin : g_range_chk
        assign fetch_in_range = (fetch_addr < ADDR_W'(DEPTH));
    end else begin : g_range_all
        assign fetch_in_range = 1'b1;
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        load_ready = 1'b0;
        accept     = 1'b0;
        word_done  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_ptr;
        mem_wdata  = NOOP;
        asm_word   = asm_reg;
        asm_word[8*byte_cnt +: 8] = load_byte;

        case (state)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr == ADDR_W'(DEPTH - 1)) next_state = S_RUN;
            end
            S_RUN: begin
                busy = 1'b0;
                if (load_start) next_state = S_LOAD;
            end
            S_LOAD: begin
                load_ready = 1'b1;
                accept     = load_valid;
                word_done  = accept && (byte_cnt == BC_W'(BYTES - 1));
                if (word_done) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr;
                    mem_wdata = asm_word;
                end
                // A completing word is written on the same edge the session closes.
                if (load_end || (word_done && wr_ptr == ADDR_W'(DEPTH - 1)))
                    next_state = S_RUN;
            end
            default: next_state = S_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_CLEAR;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr     <= '0;
            wr_ptr      <= '0;
            byte_cnt    <= '0;
            asm_reg     <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            load_done   <= 1'b0;
            load_count  <= '0;
        end else begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
            load_done   <= (state == S_LOAD) && (next_state == S_RUN);

            case (state)
                S_CLEAR: clr_ptr <= clr_ptr + 1'b1;
                S_RUN: begin
                    if (load_start) begin
                        wr_ptr     <= '0;
                        byte_cnt   <= '0;
                        load_count <= '0;
                    end else if (fetch_en) begin
                        instr_valid <= 1'b1;
                        instr_out   <= fetch_in_range ? mem[fetch_addr] : NOOP;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        asm_reg <= asm_word;
                        if (word_done) begin
                            byte_cnt   <= '0;
                            wr_ptr     <= wr_ptr + 1'b1;
                            load_count <= load_count + 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array has no reset branch; the CLEAR sweep fills it instead,
    // which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule
